// File: rtl/vga_pkg.sv
// ---------------------------------------------------------------------------
// vga_pkg
// Shared definitions for the VGA/DVI raster timing generator:
//   - standard mode timings (640x480@60 default, 800x600@60 alternative)
//   - timing_t: the bundle of per-pixel timing signals carried through the
//     lookahead delay pipe
//   - idle_timing(): the inactive value of that bundle for given polarities
// ---------------------------------------------------------------------------
package vga_pkg;

  // 640x480@60 (25.175 MHz pixel clock), negative syncs
  localparam int VGA640_H_ACTIVE = 640;
  localparam int VGA640_H_FP     = 16;
  localparam int VGA640_H_SYNC   = 96;
  localparam int VGA640_H_BP     = 48;
  localparam int VGA640_V_ACTIVE = 480;
  localparam int VGA640_V_FP     = 10;
  localparam int VGA640_V_SYNC   = 2;
  localparam int VGA640_V_BP     = 33;
  localparam bit VGA640_HS_POL   = 1'b0;
  localparam bit VGA640_VS_POL   = 1'b0;

  // 800x600@60 (40 MHz pixel clock), positive syncs
  localparam int SVGA800_H_ACTIVE = 800;
  localparam int SVGA800_H_FP     = 40;
  localparam int SVGA800_H_SYNC   = 128;
  localparam int SVGA800_H_BP     = 88;
  localparam int SVGA800_V_ACTIVE = 600;
  localparam int SVGA800_V_FP     = 1;
  localparam int SVGA800_V_SYNC   = 4;
  localparam int SVGA800_V_BP     = 23;
  localparam bit SVGA800_HS_POL   = 1'b1;
  localparam bit SVGA800_VS_POL   = 1'b1;

  typedef struct packed {
    logic hs;
    logic vs;
    logic de;
    logic line_end;
    logic frame_end;
    logic animate;
  } timing_t;

  localparam int TIMING_W = $bits(timing_t);

  // Syncs sit at their deasserted level, everything else low.
  function automatic timing_t idle_timing(input logic hs_pol, input logic vs_pol);
    timing_t t;
    t    = '0;
    t.hs = ~hs_pol;
    t.vs = ~vs_pol;
    return t;
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// ---------------------------------------------------------------------------
// vga_timing_gen_if
// Video timing bundle produced by vga_timing_gen and consumed by the pixel
// pipeline / framebuffer reader.
//   o_hs, o_vs         sync outputs (polarity set by the generator)
//   o_de               data enable, high in the active area
//   o_x [X_W], o_y [Y_W] pixel address (leads the timing signals by LOOKAHEAD)
//   o_line_end         one-strobe pulse on the last pixel of each line
//   o_frame_end        one-strobe pulse on the last pixel of each frame
//   o_animate          one-strobe pulse on the last pixel of the last visible line
//   o_frame_cnt [FRAME_W] completed-frame count, wraps
// master: the generator (drives everything); slave: the consumer.
// ---------------------------------------------------------------------------
interface vga_timing_gen_if #(
  parameter int X_W     = 10,
  parameter int Y_W     = 9,
  parameter int FRAME_W = 8
);
  logic               o_hs;
  logic               o_vs;
  logic               o_de;
  logic [X_W-1:0]     o_x;
  logic [Y_W-1:0]     o_y;
  logic               o_line_end;
  logic               o_frame_end;
  logic               o_animate;
  logic [FRAME_W-1:0] o_frame_cnt;

  modport master (
    output o_hs, o_vs, o_de, o_x, o_y,
    output o_line_end, o_frame_end, o_animate, o_frame_cnt
  );

  modport slave (
    input o_hs, o_vs, o_de, o_x, o_y,
    input o_line_end, o_frame_end, o_animate, o_frame_cnt
  );
endinterface

// File: rtl/vga_delay_pipe.sv
// ---------------------------------------------------------------------------
// vga_delay_pipe
// Strobe-enabled shift register of DEPTH stages, WIDTH bits wide. DEPTH=0 is
// a plain wire. Every stage resets (async) and flushes (sync) to INIT so the
// pipe never emits anything but idle values after a reset or restart.
//   i_clk, i_rst_n  clock, asynchronous active-low reset
//   i_stb           advance enable
//   i_flush         synchronous fill with INIT (wins over i_stb)
//   i_d / o_q       pipe input / output
// ---------------------------------------------------------------------------
module vga_delay_pipe #(
  parameter int               WIDTH = 1,
  parameter int               DEPTH = 0,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_stb,
  input  logic             i_flush,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  if (DEPTH == 0) begin : g_bypass
    assign o_q = i_d;
  end else begin : g_pipe
    logic [WIDTH-1:0] stage [DEPTH];

    // NOTE: the stages are an array but are reset like ordinary flops on
    // purpose: the outputs must show idle values straight after reset.
    // NOTE: non-blocking assignments let every stage sample the previous
    // stage's old value, giving a true shift rather than a ripple-through.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= INIT;
      end else if (i_flush) begin
        for (int i = 0; i < DEPTH; i++) stage[i] <= INIT;
      end else if (i_stb) begin
        stage[0] <= i_d;
        for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
      end
    end

    assign o_q = stage[DEPTH-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// ---------------------------------------------------------------------------
// vga_timing_gen
// Parametrised VGA/DVI raster timing generator. A (h,v) raster counter
// advances once per pixel strobe; its position is decoded into a pixel
// address and a timing bundle. The address is registered once (1 strobe);
// the timing bundle goes through a LOOKAHEAD-deep delay pipe plus an output
// register, so o_x/o_y lead o_de/o_hs/o_vs by LOOKAHEAD strobes, giving a
// framebuffer read of that latency time to return data.
//   i_clk      base clock
//   i_rst_n    asynchronous active-low reset
//   i_pix_stb  pixel strobe; nothing advances while low
//   i_restart  synchronous restart to (0,0), outputs idle, frame count kept
//   vid        vga_timing_gen_if master: syncs, de, x/y, pulses, frame count
// ---------------------------------------------------------------------------
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = VGA640_H_ACTIVE,
  parameter int H_FP      = VGA640_H_FP,
  parameter int H_SYNC    = VGA640_H_SYNC,
  parameter int H_BP      = VGA640_H_BP,
  parameter int V_ACTIVE  = VGA640_V_ACTIVE,
  parameter int V_FP      = VGA640_V_FP,
  parameter int V_SYNC    = VGA640_V_SYNC,
  parameter int V_BP      = VGA640_V_BP,
  parameter bit HS_POL    = VGA640_HS_POL,
  parameter bit VS_POL    = VGA640_VS_POL,
  parameter int LOOKAHEAD = 0,
  parameter int FRAME_W   = 8
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_pix_stb,
  input  logic             i_restart,
  vga_timing_gen_if.master vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int H_W     = $clog2(H_TOTAL);
  localparam int V_W     = $clog2(V_TOTAL);
  localparam int X_W     = $clog2(H_ACTIVE);
  localparam int Y_W     = $clog2(V_ACTIVE);

  localparam int HS_START = H_ACTIVE + H_FP;
  localparam int HS_END   = HS_START + H_SYNC;
  localparam int VS_START = V_ACTIVE + V_FP;
  localparam int VS_END   = VS_START + V_SYNC;

  localparam logic [H_W-1:0] H_LAST  = H_W'(H_TOTAL - 1);
  localparam logic [V_W-1:0] V_LAST  = V_W'(V_TOTAL - 1);
  localparam logic [V_W-1:0] V_ANIM  = V_W'(V_ACTIVE - 1);
  localparam logic [Y_W-1:0] Y_LAST  = Y_W'(V_ACTIVE - 1);
  localparam timing_t        IDLE    = idle_timing(HS_POL, VS_POL);

  // Elaboration-time parameter checks.
  if (H_ACTIVE < 1 || V_ACTIVE < 1) begin : g_bad_active
    $error("vga_timing_gen: H_ACTIVE and V_ACTIVE must be >= 1");
  end
  if (H_SYNC < 1 || V_SYNC < 1) begin : g_bad_sync
    $error("vga_timing_gen: H_SYNC and V_SYNC must be >= 1");
  end
  if (LOOKAHEAD < 0 || LOOKAHEAD > 4) begin : g_bad_lookahead
    $error("vga_timing_gen: LOOKAHEAD must be in 0..4");
  end

  // -------------------------------------------------------------------------
  // Raster counter
  // -------------------------------------------------------------------------
  logic [H_W-1:0] h;
  logic [V_W-1:0] v;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      h <= '0;
      v <= '0;
    end else if (i_restart) begin
      h <= '0;
      v <= '0;
    end else if (i_pix_stb) begin
      if (h == H_LAST) begin
        h <= '0;
        v <= (v == V_LAST) ? '0 : v + 1'b1;
      end else begin
        h <= h + 1'b1;
      end
    end
  end

  // -------------------------------------------------------------------------
  // Decode of the current raster position
  // -------------------------------------------------------------------------
  timing_t        cur;
  logic [X_W-1:0] x_nxt;
  logic [Y_W-1:0] y_nxt;
  logic           h_act;
  logic           v_act;
  logic           line_end;

  // NOTE: every output of this block gets a default first, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    cur      = IDLE;
    x_nxt    = '0;
    y_nxt    = Y_LAST;   // y parks on the last visible line during vblank
    h_act    = int'(h) < H_ACTIVE;
    v_act    = int'(v) < V_ACTIVE;
    line_end = (h == H_LAST);

    if (h_act) x_nxt = h[X_W-1:0];
    if (v_act) y_nxt = v[Y_W-1:0];

    if (int'(h) >= HS_START && int'(h) < HS_END) cur.hs = HS_POL;
    if (int'(v) >= VS_START && int'(v) < VS_END) cur.vs = VS_POL;
    cur.de        = h_act & v_act;
    cur.line_end  = line_end;
    cur.frame_end = line_end & (v == V_LAST);
    cur.animate   = line_end & (v == V_ANIM);
  end

  // -------------------------------------------------------------------------
  // Lookahead delay for the timing bundle
  // -------------------------------------------------------------------------
  timing_t pipe_q;

  vga_delay_pipe #(
    .WIDTH (TIMING_W),
    .DEPTH (LOOKAHEAD),
    .INIT  (IDLE)
  ) u_pipe (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_stb   (i_pix_stb),
    .i_flush (i_restart),
    .i_d     (cur),
    .o_q     (pipe_q)
  );

  // -------------------------------------------------------------------------
  // Output registers
  // -------------------------------------------------------------------------
  timing_t            timing_q;
  logic [X_W-1:0]     x_q;
  logic [Y_W-1:0]     y_q;
  logic [FRAME_W-1:0] frame_cnt_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      timing_q    <= IDLE;
      x_q         <= '0;
      y_q         <= '0;
      frame_cnt_q <= '0;
    end else if (i_restart) begin
      // The frame count survives a restart; only the raster is realigned.
      timing_q <= IDLE;
      x_q      <= '0;
      y_q      <= '0;
    end else if (i_pix_stb) begin
      timing_q <= pipe_q;
      x_q      <= x_nxt;
      y_q      <= y_nxt;
      // Counted on the edge that registers o_frame_end high.
      if (pipe_q.frame_end) frame_cnt_q <= frame_cnt_q + 1'b1;
    end
  end

  assign vid.o_hs        = timing_q.hs;
  assign vid.o_vs        = timing_q.vs;
  assign vid.o_de        = timing_q.de;
  assign vid.o_line_end  = timing_q.line_end;
  assign vid.o_frame_end = timing_q.frame_end;
  assign vid.o_animate   = timing_q.animate;
  assign vid.o_x         = x_q;
  assign vid.o_y         = y_q;
  assign vid.o_frame_cnt = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// ---------------------------------------------------------------------------
// tb_vga_timing_gen
// Three generators share clock and reset:
//   u_a  default 640x480, LOOKAHEAD=0  - line timing, reset, restart
//   u_b  small 8x4 mode, HS_POL=1, FRAME_W=2 - frame timing, gating, wrap
//   u_c  small 8x4 mode, LOOKAHEAD=2  - address lead over de/hs
// Small mode: 12 strobes/line (hs high at h=9..10), 7 lines/frame, vs low at
// v=5, animate at v=3,h=11, frame_end at strobe 84 of each frame.
// ---------------------------------------------------------------------------
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n;
  logic stb_a, stb_b, stb_c;
  logic rs_a, rs_b, rs_c;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  vga_timing_gen_if #(.X_W(10), .Y_W(9), .FRAME_W(8)) vid_a ();
  vga_timing_gen_if #(.X_W(3),  .Y_W(2), .FRAME_W(2)) vid_b ();
  vga_timing_gen_if #(.X_W(3),  .Y_W(2), .FRAME_W(2)) vid_c ();

  vga_timing_gen #(.LOOKAHEAD(0)) u_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb_a), .i_restart(rs_a), .vid(vid_a)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .LOOKAHEAD(0), .FRAME_W(2)
  ) u_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb_b), .i_restart(rs_b), .vid(vid_b)
  );

  vga_timing_gen #(
    .H_ACTIVE(8), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b0), .LOOKAHEAD(2), .FRAME_W(2)
  ) u_c (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_stb(stb_c), .i_restart(rs_c), .vid(vid_c)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the active edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  int hs_cnt, hs_first, de_cnt, le_cnt, le_pos, vs_cnt, vs_first;
  int fe_cnt, fe_pos, an_cnt, an_pos;
  logic [31:0] x640, x641, y641, y70;
  logic [31:0] x_log [1:14];
  logic        de_log [1:14];
  logic        hs_log [1:14];
  logic        le_log [1:14];

  initial begin
    rst_n = 1'b0;
    {stb_a, stb_b, stb_c} = '0;
    {rs_a, rs_b, rs_c}    = '0;
    #12;

    // ---- reset state ----------------------------------------------------
    check("rst_a_hs",  vid_a.o_hs, 1);
    check("rst_a_vs",  vid_a.o_vs, 1);
    check("rst_a_de",  vid_a.o_de, 0);
    check("rst_a_x",   vid_a.o_x, 0);
    check("rst_a_y",   vid_a.o_y, 0);
    check("rst_a_le",  vid_a.o_line_end, 0);
    check("rst_a_cnt", vid_a.o_frame_cnt, 0);
    check("rst_c_hs",  vid_c.o_hs, 0);   // HS_POL=1 idles low

    @(negedge clk);
    rst_n = 1'b1;

    // ---- default mode: one full line ------------------------------------
    stb_a = 1'b1;
    hs_cnt = 0; hs_first = 0; de_cnt = 0; le_cnt = 0; le_pos = 0;
    x640 = '1; x641 = '1; y641 = '1;
    for (int s = 1; s <= 800; s++) begin
      tick();
      if (vid_a.o_hs === 1'b0) begin
        hs_cnt++;
        if (hs_first == 0) hs_first = s;
      end
      if (vid_a.o_de === 1'b1) de_cnt++;
      if (vid_a.o_line_end === 1'b1) begin
        le_cnt++;
        le_pos = s;
      end
      if (s == 640) x640 = 32'(vid_a.o_x);
      if (s == 641) begin
        x641 = 32'(vid_a.o_x);
        y641 = 32'(vid_a.o_y);
      end
    end
    check("a_hs_low_len",   hs_cnt, 96);
    check("a_hs_low_first", hs_first, 657);
    check("a_de_len",       de_cnt, 640);
    check("a_le_count",     le_cnt, 1);
    check("a_le_pos",       le_pos, 800);
    check("a_x_last",       x640, 639);
    check("a_x_blank",      x641, 0);
    check("a_y_line0",      y641, 0);

    tick();  // strobe 801: h=0, v=1
    check("a_l1_x",  vid_a.o_x, 0);
    check("a_l1_y",  vid_a.o_y, 1);
    check("a_l1_de", vid_a.o_de, 1);

    repeat (300) tick();  // h=300 on line 1
    check("a_mid_x", vid_a.o_x, 300);

    // ---- asynchronous reset mid-line (no clock edge in between) ----------
    #2;
    rst_n = 1'b0;
    #1;
    check("a_arst_hs", vid_a.o_hs, 1);
    check("a_arst_de", vid_a.o_de, 0);
    check("a_arst_x",  vid_a.o_x, 0);
    check("a_arst_y",  vid_a.o_y, 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    check("a_post_rst_x",  vid_a.o_x, 0);
    check("a_post_rst_y",  vid_a.o_y, 0);
    check("a_post_rst_de", vid_a.o_de, 1);

    // ---- restart together with strobe -----------------------------------
    repeat (10) tick();
    check("a_pre_rs_x", vid_a.o_x, 10);
    rs_a = 1'b1;
    tick();
    check("a_rs_de", vid_a.o_de, 0);
    check("a_rs_hs", vid_a.o_hs, 1);
    check("a_rs_x",  vid_a.o_x, 0);
    rs_a = 1'b0;
    tick();
    check("a_after_rs_x",  vid_a.o_x, 0);
    check("a_after_rs_y",  vid_a.o_y, 0);
    check("a_after_rs_de", vid_a.o_de, 1);
    stb_a = 1'b0;

    // ---- small mode: one full frame -------------------------------------
    stb_b = 1'b1;
    hs_cnt = 0; hs_first = 0; vs_cnt = 0; vs_first = 0; de_cnt = 0;
    fe_cnt = 0; fe_pos = 0; an_cnt = 0; an_pos = 0; y70 = '1;
    for (int s = 1; s <= 84; s++) begin
      tick();
      if (s <= 12 && vid_b.o_hs === 1'b1) begin
        hs_cnt++;
        if (hs_first == 0) hs_first = s;
      end
      if (vid_b.o_vs === 1'b0) begin
        vs_cnt++;
        if (vs_first == 0) vs_first = s;
      end
      if (vid_b.o_de === 1'b1) de_cnt++;
      if (vid_b.o_frame_end === 1'b1) begin
        fe_cnt++;
        fe_pos = s;
      end
      if (vid_b.o_animate === 1'b1) begin
        an_cnt++;
        an_pos = s;
      end
      if (s == 70) y70 = 32'(vid_b.o_y);
    end
    check("b_hs_len",   hs_cnt, 2);
    check("b_hs_first", hs_first, 10);
    check("b_vs_len",   vs_cnt, 12);
    check("b_vs_first", vs_first, 61);
    check("b_de_len",   de_cnt, 32);
    check("b_fe_count", fe_cnt, 1);
    check("b_fe_pos",   fe_pos, 84);
    check("b_an_count", an_cnt, 1);
    check("b_an_pos",   an_pos, 48);
    check("b_y_vblank", y70, 3);
    check("b_cnt_1",    vid_b.o_frame_cnt, 1);

    // ---- strobe every 4th clock: one line -------------------------------
    le_cnt = 0; hs_cnt = 0;
    for (int i = 0; i < 12; i++) begin
      stb_b = 1'b1;
      tick();
      if (vid_b.o_line_end === 1'b1) le_cnt++;
      if (vid_b.o_hs === 1'b1) hs_cnt++;
      stb_b = 1'b0;
      for (int k = 0; k < 3; k++) begin
        tick();
        if (vid_b.o_line_end === 1'b1) le_cnt++;
        if (vid_b.o_hs === 1'b1) hs_cnt++;
      end
    end
    check("b_gate_le_clks", le_cnt, 4);
    check("b_gate_hs_clks", hs_cnt, 8);
    check("b_gate_cnt",     vid_b.o_frame_cnt, 1);

    // ---- frame counter wrap ---------------------------------------------
    stb_b = 1'b1;
    repeat (156) tick();   // 252 strobes = 3 frames
    check("b_cnt_3", vid_b.o_frame_cnt, 3);
    repeat (84) tick();    // 4 frames, 2-bit counter wraps
    check("b_cnt_wrap", vid_b.o_frame_cnt, 0);
    repeat (94) tick();    // one frame more, then h=9 of line 0
    check("b_cnt_5th",  vid_b.o_frame_cnt, 1);
    check("b_hs_h9",    vid_b.o_hs, 1);

    // ---- restart keeps the frame count ----------------------------------
    rs_b = 1'b1;
    tick();
    check("b_rs_cnt", vid_b.o_frame_cnt, 1);
    check("b_rs_hs",  vid_b.o_hs, 0);
    check("b_rs_vs",  vid_b.o_vs, 1);
    check("b_rs_de",  vid_b.o_de, 0);
    rs_b = 1'b0;
    tick();
    check("b_after_rs_x",  vid_b.o_x, 0);
    check("b_after_rs_y",  vid_b.o_y, 0);
    check("b_after_rs_de", vid_b.o_de, 1);
    stb_b = 1'b0;

    // ---- LOOKAHEAD=2 alignment ------------------------------------------
    stb_c = 1'b1;
    for (int s = 1; s <= 14; s++) begin
      tick();
      x_log[s]  = 32'(vid_c.o_x);
      de_log[s] = vid_c.o_de;
      hs_log[s] = vid_c.o_hs;
      le_log[s] = vid_c.o_line_end;
    end
    stb_c = 1'b0;
    check("c_x_s1",   x_log[1], 0);
    check("c_de_s1",  32'(de_log[1]), 0);
    check("c_x_s2",   x_log[2], 1);
    check("c_de_s2",  32'(de_log[2]), 0);
    check("c_de_s3",  32'(de_log[3]), 1);
    check("c_x_s8",   x_log[8], 7);
    check("c_de_s10", 32'(de_log[10]), 1);
    check("c_de_s11", 32'(de_log[11]), 0);
    check("c_hs_s11", 32'(hs_log[11]), 0);
    check("c_hs_s12", 32'(hs_log[12]), 1);
    check("c_le_s13", 32'(le_log[13]), 0);
    check("c_le_s14", 32'(le_log[14]), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Parametrised VGA/DVI raster timing generator; the successor to the fixed 640x480 sync counter.
- Adds configurable mode timing, sync polarity, and registered outputs with a fixed latency.
- Adds a pixel-address lookahead pipeline so framebuffer/ROM read latency lines up with the syncs.
- Adds data-enable, line/frame/animate pulses, a frame counter and a synchronous restart.
- Sits between the pixel-strobe divider and the pixel pipeline / framebuffer reader.

Parameters:
- H_ACTIVE, 640: visible pixels per line
- H_FP, 16: horizontal front porch (pixels)
- H_SYNC, 96: horizontal sync width (pixels)
- H_BP, 48: horizontal back porch (pixels)
- V_ACTIVE, 480: visible lines per frame
- V_FP, 10: vertical front porch (lines)
- V_SYNC, 2: vertical sync width (lines)
- V_BP, 33: vertical back porch (lines)
- HS_POL, 0: hsync asserted level (0 = active low)
- VS_POL, 0: vsync asserted level
- LOOKAHEAD, 0: strobes by which o_x/o_y lead the timing outputs; legal range 0..4
- FRAME_W, 8: width of the frame counter

Ports:
- i_clk  in  1  base clock
- i_rst_n  in  1  asynchronous active-low reset
- i_pix_stb  in  1  pixel strobe; the raster advances only when it is high
- i_restart  in  1  synchronous frame restart
- o_hs  out  1  horizontal sync
- o_vs  out  1  vertical sync
- o_de  out  1  data enable; high inside the active area
- o_x  out  $clog2(H_ACTIVE)  pixel address x (lookahead)
- o_y  out  $clog2(V_ACTIVE)  pixel address y (lookahead)
- o_line_end  out  1  one-strobe pulse at the last pixel of each line
- o_frame_end  out  1  one-strobe pulse at the last pixel of each frame
- o_animate  out  1  one-strobe pulse at the last pixel of line V_ACTIVE-1
- o_frame_cnt  out  FRAME_W  completed-frame count, wraps

Behaviour:
- Reset is asynchronous and active-low: the clock is i_clk, the reset is i_rst_n; assertion takes effect immediately, with no clock required.
- Derived totals: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP; V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Counter widths: h uses $clog2(H_TOTAL) bits, v uses $clog2(V_TOTAL) bits.
- Raster order within a line/frame: active, then front porch, then sync, then back porch.
  - h in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC) gives hs asserted.
  - v in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) gives vs asserted (for the whole line).
- Counting: on each clock edge with i_pix_stb=1, h increments.
  - At h==H_TOTAL-1: h goes to 0 and v increments.
  - At v==V_TOTAL-1 together with h==H_TOTAL-1: v goes to 0.
  - No overshoot: each line is exactly H_TOTAL strobes and each frame exactly V_TOTAL lines.
- Decode of the current (h,v):
  - x = h if h<H_ACTIVE, else 0.
  - y = v if v<V_ACTIVE, else V_ACTIVE-1.
  - de = (h<H_ACTIVE)&(v<V_ACTIVE).
  - Pulses: line_end = h==H_TOTAL-1; frame_end = line_end & v==V_TOTAL-1; animate = line_end & v==V_ACTIVE-1.
- Address outputs: o_x/o_y are registered and load decode(h,v) on every strobe edge, so latency is 1 strobe.
- Timing outputs (o_hs, o_vs, o_de, pulses):
  - Pass through a LOOKAHEAD-deep strobe-enabled delay pipe, then an output register.
  - Total latency is LOOKAHEAD+1 strobes, so o_x/o_y lead o_de by exactly LOOKAHEAD strobes.
  - With LOOKAHEAD=0 all outputs are aligned.
- o_frame_cnt increments on the same edge on which o_frame_end is registered high; it wraps at 2^FRAME_W.
- Gating: with i_pix_stb=0 all state holds, and pulses stay at their current value. Pulses are one strobe wide, not one clock wide.
- i_restart=1 at any edge, regardless of strobe, has priority over i_pix_stb:
  - (h,v) go to (0,0);
  - the delay pipe and outputs go to their idle values;
  - o_frame_cnt is unchanged.
- Reset/idle values:
  - o_hs=~HS_POL, o_vs=~VS_POL;
  - o_de=0, o_x=0, o_y=0;
  - all pulses 0, o_frame_cnt=0;
  - counters (0,0); pipe filled with the idle values.
- First strobe after reset or restart: o_x=0, o_y=0; and o_de=1 when LOOKAHEAD=0.
- Reset asserted mid-frame: all outputs go to idle immediately; the raster restarts at (0,0).
- Elaboration checks (assertions): H_SYNC, V_SYNC, H_ACTIVE, V_ACTIVE >= 1; LOOKAHEAD <= 4.

Decomposition:
- Package vga_pkg holds:
  - default 640x480@60 timing localparams, plus the 800x600 set;
  - a typedef struct for the timing-output bundle (hs, vs, de, line_end, frame_end, animate), used for the pipe payload and the idle constant.
- One sub-module: vga_delay_pipe.
  - Parameters: width and depth; depth 0 is a pass-through.
  - Strobe enable, synchronous flush, asynchronous reset to a parameter init value.

Test Plan:
- Default params, LOOKAHEAD=0, constant strobe:
  - o_hs low for exactly strobes 657..752 of each line (h=656..751); o_de high for 640 strobes per line;
  - o_frame_end every 420000 strobes; o_frame_cnt reaches 3 after 1260000 strobes.
- Vsync: o_vs low exactly while v=490..491 (1600 strobes); o_animate pulses once per frame at v=479, h=799; o_y holds 479 through the vertical blank.
- LOOKAHEAD=2: o_x=0/o_y=0 update 2 strobes before o_de rises; o_x=639 two strobes before o_de falls.
- Strobe every 4th clock: pulses last 4 clocks; o_hs low for 384 clocks.
- Reset and restart:
  - i_rst_n low mid-line at h=300 → outputs idle immediately, with no clock edge; after release, the first strobe gives x=0, y=0.
  - i_restart with strobe in the same cycle → counters (0,0), o_frame_cnt unchanged.
- Small mode (H_ACTIVE=8, H_FP=1, H_SYNC=2, H_BP=1, V_ACTIVE=4, V_FP=1, V_SYNC=1, V_BP=1, HS_POL=1, FRAME_W=2):
  - 12-strobe lines, hs high at h=9..10;
  - frame = 84 strobes; o_frame_cnt wraps 3→0 after 4 frames.
